// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - registered instruction decoder with two-entry skid buffer and warp-stop tracking
// Optional feature macro: BGPU_DECODER_PERF_EN (adds perf_inst_cnt_o / perf_stall_cnt_o)
// Opcode layout: opcode[7:4] = execution unit, opcode[3:0] = subtype; 8'hFF = warp stop.
module decoder_pipe #(
  parameter int PcWidth         = 32,
  parameter int NumWarps        = 8,
  parameter int WarpWidth       = 32,
  parameter int RegIdxWidth     = 8,
  parameter int OperandsPerInst = 2,
  parameter int EncInstWidth    = 8 + (1 + OperandsPerInst) * RegIdxWidth,
  parameter int WidWidth        = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  output logic                                   dec_ready_o,
  input  logic                                   ic_valid_i,
  input  logic [PcWidth-1:0]                     ic_pc_i,
  input  logic [WarpWidth-1:0]                   ic_act_mask_i,
  input  logic [WidWidth-1:0]                    ic_warp_id_i,
  input  logic [EncInstWidth-1:0]                ic_inst_i,
  input  logic                                   disp_ready_i,
  output logic                                   dec_valid_o,
  output logic [PcWidth-1:0]                     dec_pc_o,
  output logic [WarpWidth-1:0]                   dec_act_mask_o,
  output logic [WidWidth-1:0]                    dec_warp_id_o,
  output logic [7:0]                             dec_inst_o,
  output logic [RegIdxWidth-1:0]                 dec_dst_o,
  output logic [OperandsPerInst-1:0]             dec_operands_required_o,
  output logic [OperandsPerInst*RegIdxWidth-1:0] dec_operands_o,
  output logic                                   dec_decoded_o,
  output logic                                   dec_stop_warp_o,
  output logic [WidWidth-1:0]                    dec_decoded_warp_id_o,
  output logic [PcWidth-1:0]                     dec_decoded_next_pc_o,
  input  logic [NumWarps-1:0]                    warp_start_i,
  output logic [NumWarps-1:0]                    warp_stopped_o,
  output logic                                   stopped_warp_err_o
`ifdef BGPU_DECODER_PERF_EN
  ,
  output logic [31:0]                            perf_inst_cnt_o,
  output logic [31:0]                            perf_stall_cnt_o
`endif
);

  localparam logic [3:0] BGPU_INST_TYPE_IU = 4'h0;
  localparam logic [3:0] IU_TID            = 4'h0;
  localparam logic [3:0] IU_LDI            = 4'h1;
  localparam logic [7:0] STOP_OPCODE       = 8'hFF;

  typedef struct packed {
    logic [PcWidth-1:0]                     pc;
    logic [WarpWidth-1:0]                   mask;
    logic [WidWidth-1:0]                    wid;
    logic [7:0]                             opcode;
    logic [RegIdxWidth-1:0]                 dst;
    logic [OperandsPerInst-1:0]             req;
    logic [OperandsPerInst*RegIdxWidth-1:0] ops;
  } entry_t;

  entry_t               main_q, skid_q, in_entry;
  logic                 main_valid_q, skid_valid_q;
  logic                 in_stop, accept, push, drain;
  logic [NumWarps-1:0]  wid_onehot;
  logic [NumWarps-1:0]  warp_stopped_q;
  logic                 err_q;
  logic                 notify_q, notify_stop_q;
  logic [WidWidth-1:0]  notify_wid_q;
  logic [PcWidth-1:0]   notify_pc_q;

  // Field extraction; operand 0 sits in the highest operand slot of both encoding and output.
  always_comb begin
    in_entry        = '0;
    in_entry.pc     = ic_pc_i;
    in_entry.mask   = ic_act_mask_i;
    in_entry.wid    = ic_warp_id_i;
    in_entry.opcode = ic_inst_i[EncInstWidth-1 -: 8];
    in_entry.dst    = ic_inst_i[EncInstWidth-9 -: RegIdxWidth];
    in_entry.ops    = ic_inst_i[OperandsPerInst*RegIdxWidth-1:0];
    in_entry.req    = '1;
    if (in_entry.opcode[7:4] == BGPU_INST_TYPE_IU &&
        (in_entry.opcode[3:0] == IU_TID || in_entry.opcode[3:0] == IU_LDI)) begin
      in_entry.req = '0;
    end
  end

  // One-hot of the incoming warp id; out-of-range ids map to no warp.
  always_comb begin
    wid_onehot = '0;
    for (int w = 0; w < NumWarps; w++) begin
      if (ic_warp_id_i == WidWidth'(w)) wid_onehot[w] = 1'b1;
    end
  end

  assign in_stop = (in_entry.opcode == STOP_OPCODE);
  assign accept  = ic_valid_i && !skid_valid_q;
  assign push    = accept && !in_stop;
  assign drain   = main_valid_q && disp_ready_i;

  // Skid buffer: main feeds the dispatcher, skid catches one extra while main is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else if (drain) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        main_q <= in_entry;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q) begin
        main_q       <= in_entry;
        main_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end
    end
  end

  // Fetcher notify for every accepted instruction, stops included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      notify_q      <= 1'b0;
      notify_stop_q <= 1'b0;
      notify_wid_q  <= '0;
      notify_pc_q   <= '0;
    end else begin
      notify_q <= accept;
      if (accept) begin
        notify_stop_q <= in_stop;
        notify_wid_q  <= ic_warp_id_i;
        notify_pc_q   <= ic_pc_i + PcWidth'(1);
      end
    end
  end

  // Stopped mask (a stop beats a same-cycle start) and sticky stopped-warp error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warp_stopped_q <= '0;
      err_q          <= 1'b0;
    end else begin
      warp_stopped_q <= (warp_stopped_q & ~warp_start_i) |
                        ((accept && in_stop) ? wid_onehot : '0);
      if (accept && |(warp_stopped_q & wid_onehot)) err_q <= 1'b1;
    end
  end

`ifdef BGPU_DECODER_PERF_EN
  logic [31:0] perf_inst_q, perf_stall_q;

  // Handshake and stall counters, free-running with wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_inst_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (drain) perf_inst_q <= perf_inst_q + 32'd1;
      if (main_valid_q && !disp_ready_i) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_inst_cnt_o  = perf_inst_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

  assign dec_ready_o             = !skid_valid_q;
  assign dec_valid_o             = main_valid_q;
  assign dec_pc_o                = main_q.pc;
  assign dec_act_mask_o          = main_q.mask;
  assign dec_warp_id_o           = main_q.wid;
  assign dec_inst_o              = main_q.opcode;
  assign dec_dst_o               = main_q.dst;
  assign dec_operands_required_o = main_q.req;
  assign dec_operands_o          = main_q.ops;
  assign dec_decoded_o           = notify_q;
  assign dec_stop_warp_o         = notify_stop_q;
  assign dec_decoded_warp_id_o   = notify_wid_q;
  assign dec_decoded_next_pc_o   = notify_pc_q;
  assign warp_stopped_o          = warp_stopped_q;
  assign stopped_warp_err_o      = err_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - self-checking bench for decoder_pipe (honours BGPU_DECODER_PERF_EN)
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_ready;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_pc = '0;
  logic [31:0] ic_mask = '0;
  logic [2:0]  ic_wid = '0;
  logic [31:0] ic_inst = '0;
  logic        disp_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_mask;
  logic [2:0]  dec_wid;
  logic [7:0]  dec_inst, dec_dst;
  logic [1:0]  dec_req;
  logic [15:0] dec_ops;
  logic        dec_decoded, dec_stop;
  logic [2:0]  dec_dwid;
  logic [31:0] dec_npc;
  logic [7:0]  warp_start = '0;
  logic [7:0]  warp_stopped;
  logic        stop_err;
`ifdef BGPU_DECODER_PERF_EN
  logic [31:0] perf_inst, perf_stall;
`endif

  decoder_pipe dut (
    .clk_i(clk), .rst_i(rst), .dec_ready_o(dec_ready),
    .ic_valid_i(ic_valid), .ic_pc_i(ic_pc), .ic_act_mask_i(ic_mask),
    .ic_warp_id_i(ic_wid), .ic_inst_i(ic_inst), .disp_ready_i(disp_ready),
    .dec_valid_o(dec_valid), .dec_pc_o(dec_pc), .dec_act_mask_o(dec_mask),
    .dec_warp_id_o(dec_wid), .dec_inst_o(dec_inst), .dec_dst_o(dec_dst),
    .dec_operands_required_o(dec_req), .dec_operands_o(dec_ops),
    .dec_decoded_o(dec_decoded), .dec_stop_warp_o(dec_stop),
    .dec_decoded_warp_id_o(dec_dwid), .dec_decoded_next_pc_o(dec_npc),
    .warp_start_i(warp_start), .warp_stopped_o(warp_stopped),
    .stopped_warp_err_o(stop_err)
`ifdef BGPU_DECODER_PERF_EN
    , .perf_inst_cnt_o(perf_inst), .perf_stall_cnt_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] mask;
    logic [2:0]  wid;
    logic [7:0]  op;
    logic [7:0]  dst;
    logic [15:0] ops;
    logic [1:0]  req;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  wid;
    logic [7:0]  op;
    logic [7:0]  dst;
    logic [15:0] ops;
    logic        exp_valid;
    logic [1:0]  exp_req;
    logic [31:0] exp_npc;
    logic        exp_stop;
  } vec_t;

  int checks = 0;
  int errors = 0;

  rec_t        mq[$];
  logic [31:0] hs_pc[$];
  logic [7:0]  m_stopped;
  logic        m_err, m_dec, m_dstop;
  logic [2:0]  m_dwid;
  logic [31:0] m_dpc;
  logic [31:0] m_pi, m_ps;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] req_of(input logic [7:0] op);
    // TID (0x00) and LDI (0x01) take no register operands.
    return (op == 8'h00 || op == 8'h01) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stopped = '0; m_err = 1'b0; m_dec = 1'b0; m_dstop = 1'b0;
    m_dwid = '0; m_dpc = '0; m_pi = '0; m_ps = '0;
  endtask

  // Compare every DUT output with the reference state reached after the last edge.
  task automatic check_model();
    rec_t act;
    chk("valid", 128'(dec_valid), 128'(mq.size() > 0));
    chk("ready", 128'(dec_ready), 128'(mq.size() < 2));
    if (mq.size() > 0) begin
      act = {dec_pc, dec_mask, dec_wid, dec_inst, dec_dst, dec_ops, dec_req};
      chk("payload", 128'(act), 128'(mq[0]));
    end
    chk("decoded", 128'(dec_decoded), 128'(m_dec));
    if (m_dec) chk("notify", 128'({dec_dwid, dec_npc, dec_stop}), 128'({m_dwid, m_dpc, m_dstop}));
    chk("stopped", 128'(warp_stopped), 128'(m_stopped));
    chk("err", 128'(stop_err), 128'(m_err));
`ifdef BGPU_DECODER_PERF_EN
    chk("perf_inst", 128'(perf_inst), 128'(m_pi));
    chk("perf_stall", 128'(perf_stall), 128'(m_ps));
`endif
  endtask

  // Apply inputs for the coming edge and advance the reference model across it.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] wid,
                       input logic [7:0] op, input logic [7:0] dst, input logic [15:0] ops,
                       input logic rdy, input logic [7:0] start);
    logic pop, acc, is_stop;
    rec_t r;
    ic_valid = v; ic_pc = pc; ic_wid = wid; ic_mask = $urandom;
    ic_inst = {op, dst, ops}; disp_ready = rdy; warp_start = start;
    if (rst) begin
      model_reset();
    end else begin
      pop = (mq.size() > 0) && rdy;
      acc = v && (mq.size() < 2);
      is_stop = (op == 8'hFF);
      if (dec_valid && rdy) hs_pc.push_back(dec_pc);
      if (pop) m_pi = m_pi + 1;
      if (mq.size() > 0 && !rdy) m_ps = m_ps + 1;
      m_dec = acc;
      if (acc) begin
        m_dwid = wid; m_dpc = pc + 32'd1; m_dstop = is_stop;
        if (m_stopped[wid]) m_err = 1'b1;
      end
      m_stopped = (m_stopped & ~start) | ((acc && is_stop) ? (8'd1 << wid) : 8'd0);
      if (pop) void'(mq.pop_front());
      if (acc && !is_stop) begin
        r = '{pc: pc, mask: ic_mask, wid: wid, op: op, dst: dst, ops: ops, req: req_of(op)};
        mq.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 3'd0, 8'h00, 8'h00, 16'h0, rdy, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    tick();
    chk("rst_ctrl", 128'({dec_valid, dec_ready, dec_decoded, dec_stop, warp_stopped, stop_err}),
        128'({1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}));
    chk("rst_data", 128'({dec_pc, dec_mask, dec_wid, dec_inst, dec_dst, dec_req, dec_ops, dec_dwid, dec_npc}), 128'(0));
    rst = 1'b0;
    idle(1'b0);
  endtask

  vec_t vecs[6];
  logic [7:0] rand_ops[6];
  logic [31:0] exp_hs[3];

  initial begin
    vecs[0] = '{32'h0000_0040, 3'd2, 8'h10, 8'd5, {8'd3, 8'd4},   1'b1, 2'b11, 32'h0000_0041, 1'b0};
    vecs[1] = '{32'h0000_0100, 3'd1, 8'h01, 8'd7, {8'd9, 8'd10},  1'b1, 2'b00, 32'h0000_0101, 1'b0};
    vecs[2] = '{32'h0000_0200, 3'd0, 8'h00, 8'd1, {8'd2, 8'd6},   1'b1, 2'b00, 32'h0000_0201, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 3'd5, 8'h23, 8'd8, {8'd11, 8'd12}, 1'b1, 2'b11, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0080, 3'd4, 8'h02, 8'd9, {8'd13, 8'd14}, 1'b1, 2'b11, 32'h0000_0081, 1'b0};
    vecs[5] = '{32'h0000_0300, 3'd3, 8'hFF, 8'd0, {8'd0, 8'd0},   1'b0, 2'b00, 32'h0000_0301, 1'b1};
    rand_ops[0] = 8'h00; rand_ops[1] = 8'h01; rand_ops[2] = 8'h02;
    rand_ops[3] = 8'h10; rand_ops[4] = 8'h23; rand_ops[5] = 8'hFF;
    exp_hs[0] = 32'h1000; exp_hs[1] = 32'h1001; exp_hs[2] = 32'h1002;
    model_reset();
    do_reset();

    // Single-instruction vectors with the dispatcher ready.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b1, vecs[i].pc, vecs[i].wid, vecs[i].op, vecs[i].dst, vecs[i].ops, 1'b1, 8'h00);
      tick();
      chk("vec_valid", 128'(dec_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk("vec_fields", 128'({dec_dst, dec_ops, dec_req}),
            128'({vecs[i].dst, vecs[i].ops, vecs[i].exp_req}));
      chk("vec_notify", 128'({dec_decoded, dec_dwid, dec_npc, dec_stop}),
          128'({1'b1, vecs[i].wid, vecs[i].exp_npc, vecs[i].exp_stop}));
      idle(1'b1);
    end

    // Stop for warp 3 came from the last vector; start clears it, then stop beats start.
    tick();
    chk("stop_mask", 128'(warp_stopped), 128'(8'b0000_1000));
    drive(1'b0, 32'h0, 3'd0, 8'h00, 8'h00, 16'h0, 1'b1, 8'h08);
    tick();
    chk("start_clear", 128'(warp_stopped), 128'(8'h00));
    drive(1'b1, 32'h500, 3'd3, 8'hFF, 8'h00, 16'h0, 1'b1, 8'h08);
    tick();
    chk("stop_wins", 128'(warp_stopped), 128'(8'h08));
    drive(1'b1, 32'h504, 3'd3, 8'h10, 8'd1, 16'h0203, 1'b1, 8'h00);
    tick();
    chk("stopped_err", 128'({stop_err, dec_valid}), 128'({1'b1, 1'b1}));
    idle(1'b1);
    do_reset();

    // Backpressure: three back-to-back with dispatcher stalled, then release.
    hs_pc.delete();
    tick(); drive(1'b1, 32'h1000, 3'd1, 8'h10, 8'd1, 16'h0102, 1'b0, 8'h00);
    tick(); drive(1'b1, 32'h1001, 3'd1, 8'h10, 8'd2, 16'h0304, 1'b0, 8'h00);
    tick();
    chk("full_ready", 128'(dec_ready), 128'(1'b0));
    drive(1'b1, 32'h1002, 3'd1, 8'h10, 8'd3, 16'h0506, 1'b0, 8'h00);
    tick(); drive(1'b1, 32'h1002, 3'd1, 8'h10, 8'd3, 16'h0506, 1'b1, 8'h00);
    tick();
    chk("reopen_ready", 128'(dec_ready), 128'(1'b1));
    drive(1'b1, 32'h1002, 3'd1, 8'h10, 8'd3, 16'h0506, 1'b1, 8'h00);
    tick(); idle(1'b1);
    tick(); idle(1'b1);
    chk("hs_count", 128'(hs_pc.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      if (i < hs_pc.size()) chk("hs_order", 128'(hs_pc[i]), 128'(exp_hs[i]));

`ifdef BGPU_DECODER_PERF_EN
    // Four handshakes and three stall cycles from a clean start.
    do_reset();
    tick(); drive(1'b1, 32'h2000, 3'd0, 8'h10, 8'd1, 16'h0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin tick(); idle(1'b0); end
    for (int i = 1; i < 4; i++) begin
      tick(); drive(1'b1, 32'h2000 + 32'(i), 3'd0, 8'h10, 8'd1, 16'h0, 1'b1, 8'h00);
    end
    tick(); idle(1'b1);
    tick();
    chk("perf_counts", 128'({perf_inst, perf_stall}), 128'({32'd4, 32'd3}));
    idle(1'b1);
`endif

    // Reset in the middle of a stalled stream drops everything.
    tick(); drive(1'b1, 32'h3000, 3'd2, 8'h10, 8'd1, 16'h0, 1'b0, 8'h00);
    tick(); drive(1'b1, 32'h3001, 3'd2, 8'hFF, 8'd1, 16'h0, 1'b0, 8'h00);
    do_reset();
    tick();
    chk("post_rst_quiet", 128'({dec_valid, dec_decoded, dec_stop}), 128'(0));
    idle(1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      logic [7:0] op;
      logic [31:0] pc;
      tick();
      op = ($urandom_range(0, 9) == 0) ? rand_ops[5] : rand_ops[$urandom_range(0, 4)];
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      drive($urandom_range(0, 3) != 0, pc, 3'($urandom_range(0, 7)), op,
            8'($urandom), 16'($urandom), $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
